// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipeline of decoded control words (stage 0 = E, 1 = M, 2 = W, ...).
// Each stage holds {ctrl, valid, invalid}. Priority per stage is reset, flush, stall,
// then bubble insertion behind a stalled upstream stage, then a normal load.
// Optional feature: define CTRL_PIPE_PERF_EN to add the retired_cnt/bubble_cnt counters.
module ctrl_pipe #(
    parameter int unsigned WIDTH  = 14,
    parameter int unsigned STAGES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        ctrl_d,
    input  logic                    valid_d,
    input  logic                    invalid_d,
    input  logic [STAGES-1:0]       stall,
    input  logic [STAGES-1:0]       flush,
    output logic [STAGES*WIDTH-1:0] ctrl_q,
    output logic [STAGES-1:0]       valid_q,
    output logic [STAGES-1:0]       invalid_q,
`ifdef CTRL_PIPE_PERF_EN
    output logic [31:0]             retired_cnt,
    output logic [31:0]             bubble_cnt,
`endif
    output logic                    retire
);

    logic [STAGES*WIDTH-1:0] ctrlReg;
    logic [STAGES*WIDTH-1:0] ctrlSrc;
    logic [STAGES*WIDTH-1:0] ctrlNext;
    logic [STAGES-1:0]       validReg;
    logic [STAGES-1:0]       validSrc;
    logic [STAGES-1:0]       validNext;
    logic [STAGES-1:0]       invalidReg;
    logic [STAGES-1:0]       invalidSrc;
    logic [STAGES-1:0]       invalidNext;
    // Bit i is the stall of the stage feeding stage i; stage 0 has no upstream, so bit 0 is 0.
    logic [STAGES-1:0]       stallUp;

    assign stallUp = stall << 1;

    // Source of each stage: decode for stage 0, previous stage otherwise.
    always_comb begin
        ctrlSrc                = ctrlReg << WIDTH;
        ctrlSrc[WIDTH-1:0]     = ctrl_d;
        validSrc               = validReg << 1;
        validSrc[0]            = valid_d;
        invalidSrc             = invalidReg << 1;
        // Only a real instruction can be flagged invalid.
        invalidSrc[0]          = invalid_d & valid_d;
    end

    // Per-stage next state: flush, then stall (hold), then bubble, then load.
    always_comb begin
        ctrlNext    = ctrlSrc;
        validNext   = validSrc;
        invalidNext = invalidSrc;
        for (int i = 0; i < STAGES; i++) begin
            if (flush[i]) begin
                ctrlNext[i*WIDTH +: WIDTH] = '0;
                validNext[i]               = 1'b0;
                invalidNext[i]             = 1'b0;
            end else if (stall[i]) begin
                ctrlNext[i*WIDTH +: WIDTH] = ctrlReg[i*WIDTH +: WIDTH];
                validNext[i]               = validReg[i];
                invalidNext[i]             = invalidReg[i];
            end else if (stallUp[i]) begin
                // Upstream word is held; don't duplicate it downstream.
                ctrlNext[i*WIDTH +: WIDTH] = '0;
                validNext[i]               = 1'b0;
                invalidNext[i]             = 1'b0;
            end
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrlReg    <= '0;
            validReg   <= '0;
            invalidReg <= '0;
        end else begin
            ctrlReg    <= ctrlNext;
            validReg   <= validNext;
            invalidReg <= invalidNext;
        end
    end

    assign ctrl_q    = ctrlReg;
    assign valid_q   = validReg;
    assign invalid_q = invalidReg;
    assign retire    = validReg[STAGES-1] & ~stall[STAGES-1];

`ifdef CTRL_PIPE_PERF_EN
    logic        bubbleAny;
    logic [31:0] retiredCntReg;
    logic [31:0] bubbleCntReg;

    assign bubbleAny = |(stallUp & ~stall & ~flush);

    // Performance counters; both wrap naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            retiredCntReg <= '0;
            bubbleCntReg  <= '0;
        end else begin
            if (retire) begin
                retiredCntReg <= retiredCntReg + 32'd1;
            end
            if (bubbleAny) begin
                bubbleCntReg <= bubbleCntReg + 32'd1;
            end
        end
    end

    assign retired_cnt = retiredCntReg;
    assign bubble_cnt  = bubbleCntReg;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe (WIDTH=14, STAGES=3). The stimulus process advances a
// stage-by-stage reference model and queues the expected outputs for each cycle; a
// separate monitor pops and compares them against the DUT.
module tb_ctrl_pipe;
    localparam int W = 14;
    localparam int S = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [W-1:0]     ctrl_d;
    logic             valid_d;
    logic             invalid_d;
    logic [S-1:0]     stall;
    logic [S-1:0]     flush;
    logic [S*W-1:0]   ctrl_q;
    logic [S-1:0]     valid_q;
    logic [S-1:0]     invalid_q;
    logic             retire;
`ifdef CTRL_PIPE_PERF_EN
    logic [31:0]      retired_cnt;
    logic [31:0]      bubble_cnt;
`endif

    ctrl_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .ctrl_d    (ctrl_d),
        .valid_d   (valid_d),
        .invalid_d (invalid_d),
        .stall     (stall),
        .flush     (flush),
        .ctrl_q    (ctrl_q),
        .valid_q   (valid_q),
        .invalid_q (invalid_q),
`ifdef CTRL_PIPE_PERF_EN
        .retired_cnt (retired_cnt),
        .bubble_cnt  (bubble_cnt),
`endif
        .retire    (retire)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] ctrl;
        logic         v;
        logic         inv;
    } stage_t;

    typedef struct {
        logic [S*W-1:0] ctrl;
        logic [S-1:0]   v;
        logic [S-1:0]   inv;
        logic           ret;
        int unsigned    rc;
        int unsigned    bc;
    } exp_t;

    exp_t        expQ[$];
    stage_t      mdl[S];
    bit          known = 1'b0;
    int unsigned retCount = 0;
    int unsigned bubCount = 0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, queue what the DUT should show this cycle, advance model.
    task automatic cycle(input logic [W-1:0] c, input logic v, input logic inv,
                         input logic [S-1:0] st, input logic [S-1:0] fl, input logic r);
        exp_t   e;
        stage_t nxt[S];
        stage_t src;
        stage_t zero;
        bit     bubbled;
        @(posedge clk);
        #1;
        ctrl_d    = c;
        valid_d   = v;
        invalid_d = inv;
        stall     = st;
        flush     = fl;
        rst       = r;
        if (known) begin
            for (int i = 0; i < S; i++) begin
                e.ctrl[i*W +: W] = mdl[i].ctrl;
                e.v[i]           = mdl[i].v;
                e.inv[i]         = mdl[i].inv;
            end
            e.ret = mdl[S-1].v & ~st[S-1];
            e.rc  = retCount;
            e.bc  = bubCount;
            expQ.push_back(e);
        end
        zero.ctrl = '0;
        zero.v    = 1'b0;
        zero.inv  = 1'b0;
        if (r) begin
            for (int i = 0; i < S; i++) mdl[i] = zero;
            retCount = 0;
            bubCount = 0;
            known    = 1'b1;
        end else begin
            if (mdl[S-1].v && !st[S-1]) retCount++;
            bubbled = 1'b0;
            for (int i = 0; i < S; i++) begin
                if (i == 0) begin
                    src.ctrl = c;
                    src.v    = v;
                    src.inv  = inv & v;
                end else begin
                    src = mdl[i-1];
                end
                if (fl[i]) nxt[i] = zero;
                else if (st[i]) nxt[i] = mdl[i];
                else if (i > 0 && st[i-1]) begin
                    nxt[i]  = zero;
                    bubbled = 1'b1;
                end else nxt[i] = src;
            end
            if (bubbled) bubCount++;
            for (int i = 0; i < S; i++) mdl[i] = nxt[i];
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(W'(0), 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    // Monitor: compares the DUT against the oldest queued expectation each cycle.
    initial begin
        exp_t m;
        forever begin
            @(posedge clk);
            #3;
            if (expQ.size() > 0) begin
                m = expQ.pop_front();
                chk("ctrl_q", 64'(ctrl_q), 64'(m.ctrl));
                chk("valid_q", 64'(valid_q), 64'(m.v));
                chk("invalid_q", 64'(invalid_q), 64'(m.inv));
                chk("retire", 64'(retire), 64'(m.ret));
`ifdef CTRL_PIPE_PERF_EN
                chk("retired_cnt", 64'(retired_cnt), 64'(m.rc));
                chk("bubble_cnt", 64'(bubble_cnt), 64'(m.bc));
`endif
            end
        end
    end

    initial begin
        logic [S-1:0] st;
        logic [S-1:0] fl;
        ctrl_d    = '0;
        valid_d   = 1'b0;
        invalid_d = 1'b0;
        stall     = '0;
        flush     = '0;
        rst       = 1'b1;

        cycle(W'(0), 1'b0, 1'b0, '0, '0, 1'b1);
        cycle(W'(0), 1'b0, 1'b0, '0, '0, 1'b1);

        // Single word walks E -> M -> W and retires once.
        cycle(W'('h0060), 1'b1, 1'b0, '0, '0, 1'b0);
        idle(4);

        // Stage 0 stalled two cycles: stage 1 gets two bubbles.
        cycle(W'('h0052), 1'b1, 1'b0, '0, '0, 1'b0);
        cycle(W'('h0011), 1'b1, 1'b0, 3'b001, '0, 1'b0);
        cycle(W'('h0022), 1'b1, 1'b0, 3'b001, '0, 1'b0);
        idle(4);

        // Flush beats stall on the same stage.
        cycle(W'('h1060), 1'b1, 1'b0, '0, '0, 1'b0);
        cycle(W'('h0033), 1'b0, 1'b0, 3'b001, 3'b001, 1'b0);
        idle(3);

        // invalid_d is qualified by valid_d.
        cycle(W'('h0044), 1'b0, 1'b1, '0, '0, 1'b0);
        cycle(W'('h0055), 1'b1, 1'b1, '0, '0, 1'b0);
        idle(4);

        // Full pipe, everything stalled, then reset; restart afterwards.
        cycle(W'('h0101), 1'b1, 1'b0, '0, '0, 1'b0);
        cycle(W'('h0202), 1'b1, 1'b1, '0, '0, 1'b0);
        cycle(W'('h0303), 1'b1, 1'b0, '0, '0, 1'b0);
        cycle(W'('h0404), 1'b1, 1'b0, 3'b111, '0, 1'b0);
        cycle(W'('h0505), 1'b1, 1'b0, 3'b111, '0, 1'b1);
        cycle(W'('h0606), 1'b1, 1'b0, '0, '0, 1'b0);
        idle(4);

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            for (int b = 0; b < S; b++) begin
                st[b] = ($urandom_range(0, 99) < 20);
                fl[b] = ($urandom_range(0, 99) < 8);
            end
            cycle(W'($urandom), ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 25),
                  st, fl, ($urandom_range(0, 99) < 2));
        end
        idle(2);

        // Let the monitor drain the last expectation, with a bounded wait.
        for (int k = 0; k < 5 && expQ.size() > 0; k++) @(posedge clk);
        #5;
        chk("scoreboard_drained", 64'(expQ.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
